cp0_exception_entry: RTL
========================

# cp0_exception_entry

Exception-entry sequencer for the multicycle reference CPU; the entry-side counterpart of the exception-return path. It accepts a synchronous exception request from the execute stage or detects a pending interrupt at an instruction boundary. It then issues one atomic CP0 update (EPC, Cause.BD, Cause.ExcCode, BadVAddr, Status.EXL) and hands the exception vector to fetch over a valid/ready redirect.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: synchronous exception request.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_code` in 5: ExcCode of the request.
- `req_pc` in 32: PC of the faulting instruction.
- `req_delayed` in 1: faulting instruction sits in a delay slot.
- `req_has_badvaddr` in 1: request carries an address fault.
- `req_badvaddr` in 32: faulting address.
- `boundary_valid` in 1: an instruction is about to start this cycle.
- `boundary_pc` in 32: PC of that instruction.
- `boundary_delayed` in 1: that instruction is in a delay slot.
- `status_ie`, `status_exl`, `status_erl`, `status_bev` in 1 each: current Status bits.
- `status_im` in 8: Status.IM.
- `cause_ip` in 8: Cause.IP (software bits 1:0, hardware bits 7:2).
- `cp0_we` out 1: one-cycle commit strobe for the fields below.
- `cp0_epc_we` out 1: write EPC and Cause.BD.
- `cp0_epc` out 32: new EPC.
- `cp0_bd` out 1: new Cause.BD.
- `cp0_exccode` out 5: new Cause.ExcCode.
- `cp0_badvaddr_we` out 1: write BadVAddr.
- `cp0_badvaddr` out 32: new BadVAddr.
- `cp0_set_exl` out 1: set Status.EXL.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_pc` out 32: exception vector.
- `redirect_ready` in 1: fetch accepts the redirect.
- `irq_pending` out 1: combinational interrupt-pending flag.

## Operation
- `irq_pending = status_ie & ~status_exl & ~status_erl & |(cause_ip & status_im)`. With `CP0_TIMER_IRQ_EN`, bit 7 of `cause_ip` is ORed with the internal timer flag.
- FSM states: IDLE, COMMIT, REDIRECT.
- IDLE:
  - `req_ready=1`.
  - If `boundary_valid && irq_pending`: latch code 0, pc/delayed from the boundary inputs, no badvaddr. Go to COMMIT. `req_ready` is forced to 0 this cycle (interrupt wins a same-cycle request).
  - Otherwise, if `req_valid`: latch the req_* fields and go to COMMIT.
- COMMIT (exactly 1 cycle):
  - `cp0_we=1`, `cp0_set_exl=1`, `cp0_exccode`=latched code.
  - If the latched EXL was 0: `cp0_epc_we=1`, `cp0_epc = delayed ? pc-4 : pc` (32-bit wrap), `cp0_bd=delayed`.
  - If the latched EXL was 1: `cp0_epc_we=0` (nested entry keeps EPC/BD).
  - `cp0_badvaddr_we` = latched has_badvaddr.
  - Go to REDIRECT.
- REDIRECT:
  - `redirect_valid=1`; `redirect_pc` = 0xBFC00380 if the latched BEV is 1, else 0x80000180.
  - `redirect_pc` stays stable until `redirect_ready`; then go to IDLE.
- Status bits are latched at acceptance, so later CP0 changes do not alter an entry in flight.
- The pipeline drops `req_valid` on redirect acceptance. A request held across an interrupt entry is therefore retired by the flush.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE. The timer Count register resets to 0.
- Reset asserted mid-sequence aborts to IDLE immediately. No partial CP0 write is issued afterwards.
- Acceptance edge → `cp0_we` on the next cycle → `redirect_valid` the cycle after. The minimum entry is 3 cycles including the acceptance cycle.
- `req_ready` and `redirect_valid` are never high together.
- Back-to-back entries: the cycle after redirect acceptance is IDLE, and a new request can be accepted in that cycle.
- `cp0_*` outputs other than the write-enables are don't-care when `cp0_we=0`; the bench checks them only under `cp0_we`.

## Configuration
- `CP0_TIMER_IRQ_EN` defined:
  - Adds inputs `count_we` (1), `count_wdata` (32), `compare_we` (1), `compare_wdata` (32), and output `count` (32).
  - Count increments every second cycle via an internal toggle and wraps at 2^32; `count_we` loads it and clears the toggle.
  - When Count == Compare on an increment edge, a sticky timer flag is set. `compare_we` clears the flag and loads Compare.
  - The flag contributes to IP7 in `irq_pending`.
- Macro undefined: none of these ports or registers exist, and `irq_pending` uses `cause_ip` only.

## Test plan
- AdEL request: pc=0x80001000, delayed=0, badvaddr=0x00000003, EXL=0, BEV=0 → COMMIT: epc=0x80001000, bd=0, exccode=4, badvaddr_we=1; redirect_pc=0x80000180.
- Delay-slot Syscall: pc=0x80002004, delayed=1 → epc=0x80002000, bd=1, exccode=8, badvaddr_we=0.
- Nested entry: EXL=1, BEV=1, code 10 → epc_we=0, set_exl=1; redirect_pc=0xBFC00380.
- Interrupt vs request in the same cycle: IE=1, IM=0x04, IP=0x04, boundary_pc=0x80003000, req_valid=1 → req_ready=0, exccode=0, epc=0x80003000.
- Redirect backpressure plus reset: hold redirect_ready=0 for 5 cycles → redirect_pc stable; assert reset → all outputs 0 within the same cycle, FSM in IDLE.
- With `CP0_TIMER_IRQ_EN`: write count=0, compare=3, IE=1, IM[7]=1 → irq_pending rises 6–7 cycles later; compare_we clears it.

Source files
------------

// File: rtl/cp0_exception_entry.sv
// cp0_exception_entry: exception-entry sequencer that turns an execute-stage
//   exception request, or an interrupt seen at an instruction boundary, into
//   one atomic CP0 update followed by a redirect of fetch to the vector.
// Latency: acceptance cycle -> cp0_we strobe next cycle -> redirect_valid the
//   cycle after (3-cycle minimum entry including acceptance).
// Backpressure: req_ready is high only in IDLE; redirect_valid holds with a
//   stable redirect_pc until redirect_ready.
//
// Optional feature macro: CP0_TIMER_IRQ_EN (Count/Compare timer feeding IP7).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_*                      synchronous exception request (valid/ready)
//   boundary_*                 instruction-boundary strobe used for interrupts
//   status_*, cause_ip         current CP0 Status/Cause state
//   cp0_*                      one-cycle CP0 commit (qualified by cp0_we)
//   redirect_*                 exception vector to fetch (valid/ready)
//   irq_pending                combinational interrupt-pending flag
//   count_we/count_wdata/compare_we/compare_wdata/count  (CP0_TIMER_IRQ_EN only)

module cp0_exception_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_code,
  input  logic [31:0] req_pc,
  input  logic        req_delayed,
  input  logic        req_has_badvaddr,
  input  logic [31:0] req_badvaddr,
  input  logic        boundary_valid,
  input  logic [31:0] boundary_pc,
  input  logic        boundary_delayed,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        status_erl,
  input  logic        status_bev,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  output logic        cp0_we,
  output logic        cp0_epc_we,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_set_exl,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        irq_pending
`ifdef CP0_TIMER_IRQ_EN
  ,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COMMIT   = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [31:0] VEC_BEV   = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORML = 32'h8000_0180;

  logic [1:0]  state;

  // Entry context captured at acceptance; Status bits are snapshotted so a
  // CP0 write landing mid-entry cannot change the EPC decision or vector.
  logic [4:0]  lat_code;
  logic [31:0] lat_pc;
  logic        lat_delayed;
  logic        lat_has_badvaddr;
  logic [31:0] lat_badvaddr;
  logic        lat_exl;
  logic        lat_bev;

  logic [7:0]  ip_eff;
  logic        irq_raw;
  logic        take_irq;

`ifdef CP0_TIMER_IRQ_EN
  logic        cnt_toggle;
  logic [31:0] compare_reg;
  logic        timer_flag;
  logic [31:0] count_inc;

  assign count_inc = count + 32'd1;

  // Count advances on every second edge. The sticky flag is raised when the
  // value being written by an increment equals Compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= 32'd0;
      cnt_toggle  <= 1'b0;
      compare_reg <= 32'd0;
      timer_flag  <= 1'b0;
    end else begin
      if (count_we) begin
        count      <= count_wdata;
        cnt_toggle <= 1'b0;
      end else begin
        cnt_toggle <= ~cnt_toggle;
        if (cnt_toggle) begin
          count <= count_inc;
        end
      end

      if (compare_we) begin
        compare_reg <= compare_wdata;
        timer_flag  <= 1'b0;
      end else if (!count_we && cnt_toggle && (count_inc == compare_reg)) begin
        timer_flag <= 1'b1;
      end
    end
  end

  assign ip_eff = cause_ip | {timer_flag, 7'b0};
`else
  assign ip_eff = cause_ip;
`endif

  assign irq_raw     = status_ie & ~status_exl & ~status_erl & (|(ip_eff & status_im));
  // Masked during reset so every output reads 0 while reset is held.
  assign irq_pending = irq_raw & ~reset;

  // An interrupt at a boundary wins over a same-cycle request; the request
  // stays unaccepted and is flushed by the pipeline on redirect.
  assign take_irq  = (state == ST_IDLE) & boundary_valid & irq_raw;
  assign req_ready = (state == ST_IDLE) & ~take_irq & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      lat_code         <= 5'd0;
      lat_pc           <= 32'd0;
      lat_delayed      <= 1'b0;
      lat_has_badvaddr <= 1'b0;
      lat_badvaddr     <= 32'd0;
      lat_exl          <= 1'b0;
      lat_bev          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_irq) begin
            lat_code         <= 5'd0;
            lat_pc           <= boundary_pc;
            lat_delayed      <= boundary_delayed;
            lat_has_badvaddr <= 1'b0;
            lat_badvaddr     <= 32'd0;
            lat_exl          <= status_exl;
            lat_bev          <= status_bev;
            state            <= ST_COMMIT;
          end else if (req_valid) begin
            lat_code         <= req_code;
            lat_pc           <= req_pc;
            lat_delayed      <= req_delayed;
            lat_has_badvaddr <= req_has_badvaddr;
            lat_badvaddr     <= req_badvaddr;
            lat_exl          <= status_exl;
            lat_bev          <= status_bev;
            state            <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs decode from state, which resets asynchronously to IDLE, so a
  // reset mid-entry suppresses any further CP0 write in the same cycle.
  always_comb begin
    cp0_we          = 1'b0;
    cp0_epc_we      = 1'b0;
    cp0_epc         = 32'd0;
    cp0_bd          = 1'b0;
    cp0_exccode     = 5'd0;
    cp0_badvaddr_we = 1'b0;
    cp0_badvaddr    = 32'd0;
    cp0_set_exl     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    if (state == ST_COMMIT) begin
      cp0_we          = 1'b1;
      cp0_set_exl     = 1'b1;
      cp0_exccode     = lat_code;
      // A nested entry (EXL already set) must preserve the original EPC/BD.
      cp0_epc_we      = ~lat_exl;
      cp0_epc         = lat_delayed ? (lat_pc - 32'd4) : lat_pc;
      cp0_bd          = lat_delayed;
      cp0_badvaddr_we = lat_has_badvaddr;
      cp0_badvaddr    = lat_badvaddr;
    end else if (state == ST_REDIRECT) begin
      redirect_valid = 1'b1;
      redirect_pc    = lat_bev ? VEC_BEV : VEC_NORML;
    end
  end

endmodule
